// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one upper-memory line port between an I-cache and a D-cache.
// Memory completions are forwarded with zero added latency; a RELEASE cycle separates grants.
module mem_arbiter #(
    parameter int ByteOffsetBits = 5,
    localparam int LineSize = 8 * (2 ** ByteOffsetBits)
) (
    input  logic                clk_i,
    input  logic                rstn_i,

    input  logic [31:0]         i_addr_i,
    input  logic                i_read_en_i,
    output logic                i_read_valid_o,
    output logic [LineSize-1:0] i_read_data_o,

    input  logic [31:0]         d_addr_i,
    input  logic                d_read_en_i,
    output logic                d_read_valid_o,
    output logic [LineSize-1:0] d_read_data_o,
    input  logic                d_write_en_i,
    input  logic [LineSize-1:0] d_write_data_i,
    output logic                d_write_valid_o,

    output logic [31:0]         mem_addr_o,
    output logic                mem_read_en_o,
    input  logic                mem_read_valid_i,
    input  logic [LineSize-1:0] mem_read_data_i,
    output logic                mem_write_en_o,
    output logic [LineSize-1:0] mem_write_data_o,
    input  logic                mem_write_valid_i,

    output logic                protocol_err_o
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_e;

    state_e state_q, state_d;
    logic   lastGrant_q, lastGrant_d;
    logic   protocolErr_q, protocolErr_d;

    logic iPend, dPend;
    logic iDone, dReadDone, dWriteDone;
    logic memErr;

    assign iPend = i_read_en_i;
    assign dPend = d_read_en_i | d_write_en_i;

    always_comb begin
        mem_addr_o       = '0;
        mem_read_en_o    = 1'b0;
        mem_write_en_o   = 1'b0;
        mem_write_data_o = '0;
        case (state_q)
            SERVE_I: begin
                mem_addr_o    = i_addr_i;
                mem_read_en_o = i_read_en_i;
            end
            SERVE_D: begin
                mem_addr_o = d_addr_i;
                if (d_write_en_i) begin
                    mem_write_en_o   = 1'b1;
                    mem_write_data_o = d_write_data_i;
                end else begin
                    mem_read_en_o = d_read_en_i;
                end
            end
            default: ;
        endcase
    end

    // A completion only counts when it matches the operation currently forwarded to memory.
    assign iDone      = (state_q == SERVE_I) & mem_read_en_o & mem_read_valid_i;
    assign dReadDone  = (state_q == SERVE_D) & mem_read_en_o & mem_read_valid_i;
    assign dWriteDone = (state_q == SERVE_D) & mem_write_en_o & mem_write_valid_i;
    assign memErr     = (mem_read_valid_i & ~mem_read_en_o) | (mem_write_valid_i & ~mem_write_en_o);

    assign i_read_valid_o  = iDone;
    assign d_read_valid_o  = dReadDone;
    assign d_write_valid_o = dWriteDone;
    assign i_read_data_o   = mem_read_data_i;
    assign d_read_data_o   = mem_read_data_i;
    assign protocol_err_o  = protocolErr_q;

    always_comb begin
        state_d       = state_q;
        lastGrant_d   = lastGrant_q;
        protocolErr_d = protocolErr_q | memErr;
        case (state_q)
            IDLE: begin
                if (iPend && dPend) begin
                    state_d = lastGrant_q ? SERVE_I : SERVE_D;
                end else if (iPend) begin
                    state_d = SERVE_I;
                end else if (dPend) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I: begin
                if (iDone) begin
                    state_d     = RELEASE;
                    lastGrant_d = 1'b0;
                end else if (!iPend) begin
                    state_d = RELEASE;
                end
            end
            SERVE_D: begin
                if (dReadDone || dWriteDone) begin
                    state_d     = RELEASE;
                    lastGrant_d = 1'b1;
                end else if (!dPend) begin
                    state_d = RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            lastGrant_q   <= 1'b1;
            protocolErr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lastGrant_q   <= lastGrant_d;
            protocolErr_q <= protocolErr_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ByteOffsetBits, default 5, byte offset bits per line; LineSize = 8*2**ByteOffsetBits (256 by default).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 i_addr_i  input  32  instruction-cache line address.
REQ-005 i_read_en_i  input  1  instruction-cache line read request, level, held until i_read_valid_o.
REQ-006 i_read_valid_o  output  1  instruction read data valid, one-cycle pulse.
REQ-007 i_read_data_o  output  LineSize  instruction line data.
REQ-008 d_addr_i  input  32  data-cache line address.
REQ-009 d_read_en_i  input  1  data-cache line read request, level.
REQ-010 d_read_valid_o  output  1  data read valid, one-cycle pulse.
REQ-011 d_read_data_o  output  LineSize  data line read data.
REQ-012 d_write_en_i  input  1  data-cache write-through line write request, level.
REQ-013 d_write_data_i  input  LineSize  line to write.
REQ-014 d_write_valid_o  output  1  write acknowledge, one-cycle pulse.
REQ-015 mem_addr_o  output  32  address to shared upper memory.
REQ-016 mem_read_en_o  output  1  memory read request.
REQ-017 mem_read_valid_i  input  1  memory read data valid.
REQ-018 mem_read_data_i  input  LineSize  memory read data.
REQ-019 mem_write_en_o  output  1  memory write request.
REQ-020 mem_write_data_o  output  LineSize  memory write data.
REQ-021 mem_write_valid_i  input  1  memory write complete.
REQ-022 protocol_err_o  output  1  sticky error flag.

Function
REQ-023 FSM states: IDLE, SERVE_I, SERVE_D, RELEASE; state and a 1-bit last_grant (0=I, 1=D) are registered.
REQ-024 IDLE: d pending = d_read_en_i|d_write_en_i; if only one requester is pending, go to its SERVE state next cycle; if both are pending, grant the one not equal to last_grant (round-robin); if none, stay.
REQ-025 IDLE and RELEASE: mem_read_en_o=0, mem_write_en_o=0, mem_addr_o=0, all requester valids 0.
REQ-026 SERVE_I: mem_addr_o=i_addr_i, mem_read_en_o=i_read_en_i, mem_write_en_o=0.
REQ-027 SERVE_D: mem_addr_o=d_addr_i; if d_write_en_i then mem_write_en_o=1, mem_read_en_o=0, mem_write_data_o=d_write_data_i (write wins if both are asserted); else mem_read_en_o=d_read_en_i.
REQ-028 mem_read_data_i is routed combinationally to both i_read_data_o and d_read_data_o; only the granted port's valid is asserted.
REQ-029 In SERVE_x, a completion (mem_read_valid_i for reads, mem_write_valid_i for writes) asserts the matching port valid in the same cycle (zero added latency), sets last_grant=x, and moves to RELEASE.
REQ-030 RELEASE lasts exactly one cycle, then IDLE; this guarantees requesters drop their level enables before re-arbitration.
REQ-031 If the granted requester deasserts all its enables in SERVE_x before completion, go to RELEASE without asserting a valid; last_grant is unchanged.
REQ-032 A memory valid that arrives in IDLE or RELEASE, or that does not match the forwarded operation, is ignored and sets protocol_err_o=1 on the next edge.
REQ-033 Requests are never lost: a requester that is not granted keeps its level request and is served in the next arbitration; worst-case wait is one transaction of the other port plus 2 cycles.
REQ-034 Minimum request-to-grant latency is 1 cycle (IDLE->SERVE); back-to-back transactions occupy at least 3 cycles each (IDLE, SERVE, RELEASE).

Reset
REQ-035 On rstn_i=0: state=IDLE, last_grant=1 (so the first tie goes to I), protocol_err_o=0; all enables and valids are 0 while reset is asserted.
REQ-036 Reset asserted mid-transaction aborts it immediately; no valid is issued for the aborted transaction.

Verification
REQ-037 I read only, addr 0x100, memory returns valid after 3 cycles with 256'hA5.. -> mem_addr_o=0x100, mem_read_en_o=1 from cycle 1, i_read_valid_o is a single-cycle pulse with i_read_data_o=256'hA5.., d valid stays 0.
REQ-038 I and D read requested in the same cycle after reset -> I served first, then RELEASE, IDLE, D served; d_read_valid_o arrives no earlier than 3 cycles after i_read_valid_o.
REQ-039 D write addr 0x2000 with data 256'h1234 -> mem_write_en_o=1, mem_write_data_o=256'h1234, d_write_valid_o pulses when mem_write_valid_i=1, mem_read_en_o stays 0.
REQ-040 I and D continuously requesting, 6 transactions -> grants alternate I,D,I,D,I,D.
REQ-041 mem_read_valid_i pulsed while in IDLE -> no requester valid, protocol_err_o=1 until reset.
REQ-042 rstn_i driven low during SERVE_D -> mem enables drop to 0 asynchronously, d valids stay 0, FSM in IDLE after release.
